// File: rtl/debounce_bank.sv
`default_nettype none
// debounce_bank: multi-channel switch debouncer with a two-flop synchroniser,
// a stability counter, rise/fall strobes and an optional long-press strobe per channel.
module debounce_bank #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 20,
  parameter int HOLD_LIMIT     = 0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Bouncy,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Hold
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0] meta_q;
  logic [NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0] deb_q;
  logic [NUM_CH-1:0] deb_d;
  logic [NUM_CH-1:0] rise_q;
  logic [NUM_CH-1:0] rise_d;
  logic [NUM_CH-1:0] fall_q;
  logic [NUM_CH-1:0] fall_d;
  logic [NUM_CH-1:0] commit;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  // Any cycle where the synchronised input agrees with the committed level restarts the count.
  always_comb begin
    commit = '0;
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      cnt_d[n] = '0;
      if (sync_q[n] != deb_q[n]) begin
        if (cnt_q[n] == CNT_MAX) begin
          commit[n] = 1'b1;
          deb_d[n]  = sync_q[n];
          rise_d[n] = sync_q[n];
          fall_d[n] = ~sync_q[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q <= '0;
      sync_q <= '0;
      deb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      meta_q <= i_Bouncy;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign o_Debounced = deb_q;
  assign o_Rise      = rise_q;
  assign o_Fall      = fall_q;

  generate
    if (HOLD_LIMIT > 0) begin : g_hold
      localparam int               HOLD_W   = $clog2(HOLD_LIMIT + 1);
      localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);
      localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_LIMIT - 1);

      logic [HOLD_W-1:0] hold_cnt_q [NUM_CH];
      logic [HOLD_W-1:0] hold_cnt_d [NUM_CH];
      logic [NUM_CH-1:0] hold_q;
      logic [NUM_CH-1:0] hold_d;

      // A commit in either direction clears the count, so a release can never fire the strobe.
      always_comb begin
        hold_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
          hold_cnt_d[n] = '0;
          if (!commit[n] && deb_q[n]) begin
            if (hold_cnt_q[n] != HOLD_MAX) begin
              hold_cnt_d[n] = hold_cnt_q[n] + 1'b1;
            end else begin
              hold_cnt_d[n] = hold_cnt_q[n];
            end
            hold_d[n] = (hold_cnt_q[n] == HOLD_PRE);
          end
        end
      end

      always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
          hold_q <= '0;
          for (int n = 0; n < NUM_CH; n++) begin
            hold_cnt_q[n] <= '0;
          end
        end else begin
          hold_q <= hold_d;
          for (int n = 0; n < NUM_CH; n++) begin
            hold_cnt_q[n] <= hold_cnt_d[n];
          end
        end
      end

      assign o_Hold = hold_q;
    end else begin : g_no_hold
      assign o_Hold = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// tb_debounce_bank: directed stimulus; expected strobe events are queued with their
// cycle stamp and popped by a monitor whenever the DUT raises any strobe.
module tb_debounce_bank;

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] hold;
    logic [1:0] deb;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [1:0] bouncy;
  logic [1:0] deb;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] hold;

  int  cyc;
  int  total;
  int  bad;
  ev_t expq[$];

  debounce_bank #(
    .NUM_CH        (2),
    .DEBOUNCE_LIMIT(4),
    .HOLD_LIMIT    (10)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_Bouncy   (bouncy),
    .o_Debounced(deb),
    .o_Rise     (rise),
    .o_Fall     (fall),
    .o_Hold     (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input logic [1:0] r, input logic [1:0] f,
                           input logic [1:0] h, input logic [1:0] d);
    ev_t e;
    e.cyc  = c;
    e.rise = r;
    e.fall = f;
    e.hold = h;
    e.deb  = d;
    expq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: any strobe on the DUT must match the oldest queued event.
  always @(negedge clk) begin
    if ((rise | fall | hold) != 2'b00) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: rise=%b fall=%b hold=%b at cyc %0d, none expected",
                 rise, fall, hold, cyc);
      end else begin
        ev_t e;
        e = expq.pop_front();
        if (e.cyc != cyc) begin
          bad++;
          $display("FAIL event_cycle: seen at cyc %0d expected cyc %0d", cyc, e.cyc);
        end
        total++;
        if ({rise, fall, hold, deb} !== {e.rise, e.fall, e.hold, e.deb}) begin
          bad++;
          $display("FAIL event_value: rise/fall/hold/deb=%b/%b/%b/%b expected %b/%b/%b/%b",
                   rise, fall, hold, deb, e.rise, e.fall, e.hold, e.deb);
        end
      end
    end
  end

  initial begin
    int t;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    bouncy = 2'b00;
    tick(3);
    check("reset_deb", deb, 2'b00);
    check("reset_rise", rise, 2'b00);
    check("reset_fall", fall, 2'b00);
    check("reset_hold", hold, 2'b00);
    rst = 1'b0;
    tick(4);

    // Clean step on ch0: rise 6 clocks after the first sampling edge, hold 10 later.
    t = cyc;
    bouncy = 2'b01;
    expect_ev(t + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    expect_ev(t + 16, 2'b00, 2'b00, 2'b01, 2'b01);
    tick(5);
    check("step_not_yet", deb, 2'b00);
    tick(15);
    check("step_level", deb, 2'b01);
    t = cyc;
    bouncy = 2'b00;
    expect_ev(t + 6, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(10);

    // Glitch of 3 clocks is rejected; 4 clocks passes and then falls.
    bouncy = 2'b01;
    tick(3);
    bouncy = 2'b00;
    tick(10);
    check("glitch3_level", deb, 2'b00);
    t = cyc;
    bouncy = 2'b01;
    expect_ev(t + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    expect_ev(t + 10, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(4);
    bouncy = 2'b00;
    tick(12);

    // Bounce: 2-clock segments for 20 clocks, then steady high.
    for (int k = 0; k < 10; k++) begin
      bouncy = (k % 2 == 0) ? 2'b01 : 2'b00;
      tick(2);
    end
    t = cyc;
    bouncy = 2'b01;
    expect_ev(t + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    expect_ev(t + 16, 2'b00, 2'b00, 2'b01, 2'b01);
    tick(20);
    t = cyc;
    bouncy = 2'b00;
    expect_ev(t + 6, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(10);

    // Long press on ch1 held 30 clocks, then a short 8-clock press.
    t = cyc;
    bouncy = 2'b10;
    expect_ev(t + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    expect_ev(t + 16, 2'b00, 2'b00, 2'b10, 2'b10);
    expect_ev(t + 36, 2'b00, 2'b10, 2'b00, 2'b00);
    tick(30);
    bouncy = 2'b00;
    tick(10);
    t = cyc;
    bouncy = 2'b10;
    expect_ev(t + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    expect_ev(t + 14, 2'b00, 2'b10, 2'b00, 2'b00);
    tick(8);
    bouncy = 2'b00;
    tick(12);

    // Simultaneous: ch0 rises while ch1 falls on the same clock.
    t = cyc;
    bouncy = 2'b10;
    expect_ev(t + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    expect_ev(t + 16, 2'b00, 2'b00, 2'b10, 2'b10);
    tick(20);
    t = cyc;
    bouncy = 2'b01;
    expect_ev(t + 6, 2'b01, 2'b10, 2'b00, 2'b01);
    expect_ev(t + 16, 2'b00, 2'b00, 2'b01, 2'b01);
    tick(20);
    t = cyc;
    bouncy = 2'b00;
    expect_ev(t + 6, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(10);

    // Asynchronous reset mid-operation, inputs left high across release.
    t = cyc;
    bouncy = 2'b01;
    expect_ev(t + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    tick(8);
    bouncy = 2'b11;
    tick(2);
    check("pre_reset_level", deb, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("async_reset_deb", deb, 2'b00);
    check("async_reset_rise", rise, 2'b00);
    check("async_reset_fall", fall, 2'b00);
    check("async_reset_hold", hold, 2'b00);
    tick(3);
    t = cyc;
    rst = 1'b0;
    expect_ev(t + 6, 2'b11, 2'b00, 2'b00, 2'b11);
    expect_ev(t + 16, 2'b00, 2'b00, 2'b11, 2'b11);
    tick(20);
    t = cyc;
    bouncy = 2'b00;
    expect_ev(t + 6, 2'b00, 2'b11, 2'b00, 2'b00);
    tick(10);
    check("final_level", deb, 2'b00);

    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL missing_events: %0d expected events never seen, next at cyc %0d",
               expq.size(), expq[0].cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Parametrised multi-channel debounce filter for switches and buttons. Each channel has its own input synchroniser, stability counter, debounced level, rise and fall strobes, and an optional long-press strobe. It sits between the board's raw switch pins and the user logic (LED toggles, counters, state machines). One instance replaces a set of single-channel filters and also removes the need for separate edge detectors.

Parameters:
NUM_CH, 4, number of independent channels; must be >= 1.
DEBOUNCE_LIMIT, 20, clocks the synchronised input must differ from the debounced state before that state commits; must be >= 2.
HOLD_LIMIT, 0, clocks after a rise before the long-press strobe fires; 0 disables the hold logic (o_Hold tied to 0).

Ports:
i_Clk  input  1  system clock; all state updates on its rising edge.
i_Reset  input  1  asynchronous, active-high reset.
i_Bouncy  input  NUM_CH  raw, asynchronous switch inputs; bit n is channel n.
o_Debounced  output  NUM_CH  debounced level per channel.
o_Rise  output  NUM_CH  one-clock strobe when the channel commits 0->1.
o_Fall  output  NUM_CH  one-clock strobe when the channel commits 1->0.
o_Hold  output  NUM_CH  one-clock strobe after the channel has been high for HOLD_LIMIT clocks.

Behaviour:
- Reset is asynchronous and active-high. While i_Reset is high, every flop clears immediately:
  - synchroniser stages = 0;
  - stability and hold counters = 0;
  - o_Debounced = 0;
  - o_Rise, o_Fall, o_Hold = 0.
  Deassertion takes effect at the next clock edge.
- Reset mid-operation discards any in-progress count. No strobe is emitted because of the reset.
- Synchroniser: two flops per channel; s[n] is the output of the second flop.
- Stability counter per channel, width $clog2(DEBOUNCE_LIMIT). Each edge:
  - s[n] == o_Debounced[n]: count <= 0.
  - s[n] != state and count < DEBOUNCE_LIMIT-1: count <= count+1.
  - s[n] != state and count == DEBOUNCE_LIMIT-1 (commit): o_Debounced[n] <= s[n]; count <= 0.
  - Any single cycle where s[n] matches the state restarts the count from 0.
- Latency: a clean input step appears on o_Debounced exactly 2+DEBOUNCE_LIMIT clocks after the first edge that samples it.
- Filtering threshold: an input level held for >= DEBOUNCE_LIMIT clocks passes; DEBOUNCE_LIMIT-1 clocks or fewer is rejected.
- Strobes are registered and fire at the commit edge:
  - o_Rise[n] <= commit & s[n];
  - o_Fall[n] <= commit & ~s[n].
  - So o_Rise is high during the first cycle o_Debounced reads 1, for exactly one cycle. o_Fall mirrors this on the falling commit.
  - o_Rise and o_Fall are never both high on the same channel.
- Hold logic (HOLD_LIMIT > 0), hold counter width $clog2(HOLD_LIMIT+1):
  - Clears to 0 at a rise commit and whenever o_Debounced[n] == 0.
  - While o_Debounced[n] == 1, increments each edge and saturates at HOLD_LIMIT.
  - o_Hold[n] pulses for one clock on the edge where the count goes HOLD_LIMIT-1 -> HOLD_LIMIT, i.e. HOLD_LIMIT clocks after o_Rise[n].
  - It fires once per press. A fall before HOLD_LIMIT suppresses it.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- If the input is high at reset release, the channel commits with an o_Rise after 2+DEBOUNCE_LIMIT clocks. This is intended behaviour.

Test Plan:
- NUM_CH=2, LIMIT=4: ch0 clean 0->1 step -> o_Debounced[0]=1 and o_Rise[0]=1 for one cycle, exactly 6 clocks after the first sampling edge; ch1 stays 0 with no strobes.
- Glitch rejection: ch0 high for 3 clocks then low -> no change and no strobe. High for 4 clocks -> commits to 1; the return to 0 then commits 6 clocks after it with o_Fall[0] pulsing once.
- Bounce: ch0 toggles every 2 clocks for 20 clocks, then holds 1 -> exactly one o_Rise, 6 clocks after the final stable edge.
- Hold, HOLD_LIMIT=10: ch1 pressed and held 30 clocks -> o_Hold[1] exactly 10 clocks after o_Rise[1], once only. Released after 8 clocks high -> no o_Hold.
- Simultaneous: ch0 rises and ch1 falls on the same clock -> o_Rise[0] and o_Fall[1] in the same cycle.
- Reset: i_Reset asserted asynchronously mid-count, with ch0 debounced high -> outputs go 0 immediately with no strobe. After release with input still high -> o_Rise[0] fires 6 clocks later.
